// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO write sequencer: iterative shift-add multiply and restoring divide,
// arbitrated against MTHI/MTLO direct writes, with EX-stage stall generation.
module muldiv_hilo_ctrl #(
  parameter int ITER = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] opa_i,
  input  logic [31:0] opb_i,
  input  logic        flush_i,
  input  logic        mthi_we_i,
  input  logic        mtlo_we_i,
  input  logic [31:0] mt_data_i,
  output logic        stall_req_o,
  output logic        busy_o,
  output logic        hi_we_o,
  output logic        lo_we_o,
  output logic [31:0] hi_wdata_o,
  output logic [31:0] lo_wdata_o
);
  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   acc_q, acc_d;   // {hi, lo}: product, or {rem, quot}
  logic [31:0]   b_q, b_d;       // multiplicand or divisor
  logic          neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic          mthi_q, mthi_d, mtlo_q, mtlo_d;

  logic        sgn, accept, last, ge;
  logic [31:0] abs_a, abs_b;
  logic [32:0] msum, drem, dsub;
  logic [63:0] mul_nx, mul_fix, div_nx, div_fix;

  assign sgn    = ~op_i[0];
  assign abs_a  = (sgn && opa_i[31]) ? -opa_i : opa_i;
  assign abs_b  = (sgn && opb_i[31]) ? -opb_i : opb_i;
  assign accept = (state_q == IDLE) && start_i && !flush_i;
  assign last   = (cnt_q == CW'(ITER - 1));

  // Multiply step: conditional add into upper half keeps its carry, then shift right.
  assign msum    = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? b_q : 32'd0)};
  assign mul_nx  = {msum, acc_q[31:1]};
  assign mul_fix = neg_lo_q ? -mul_nx : mul_nx;

  // Divide step: the shifted remainder needs 33 bits to compare against the divisor.
  assign drem    = acc_q[63:31];
  assign ge      = (drem >= {1'b0, b_q});
  assign dsub    = drem - {1'b0, b_q};
  assign div_nx  = {(ge ? dsub[31:0] : drem[31:0]), acc_q[30:0], ge};
  assign div_fix = {(neg_hi_q ? -div_nx[63:32] : div_nx[63:32]),
                    (neg_lo_q ? -div_nx[31:0]  : div_nx[31:0])};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    mthi_d   = 1'b0;
    mtlo_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          cnt_d    = '0;
          neg_lo_d = sgn && (opa_i[31] ^ opb_i[31]);
          neg_hi_d = op_i[1] ? (sgn && opa_i[31]) : (sgn && (opa_i[31] ^ opb_i[31]));
          if (!op_i[1]) begin
            acc_d   = {32'd0, abs_b};
            b_d     = abs_a;
            state_d = MUL;
          end else if (opb_i == 32'd0) begin
            acc_d   = {opa_i, 32'hFFFF_FFFF};
            state_d = DONE;
          end else begin
            acc_d   = {32'd0, abs_a};
            b_d     = abs_b;
            state_d = DIV;
          end
        end else if (!start_i) begin
          mthi_d = mthi_we_i;
          mtlo_d = mtlo_we_i;
          if (mthi_we_i || mtlo_we_i) acc_d = {mt_data_i, mt_data_i};
        end
      end
      MUL: begin
        acc_d = last ? mul_fix : mul_nx;
        cnt_d = cnt_q + 1'b1;
        if (last) state_d = DONE;
      end
      DIV: begin
        acc_d = last ? div_fix : div_nx;
        cnt_d = cnt_q + 1'b1;
        if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i && state_q != IDLE) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      mthi_q   <= 1'b0;
      mtlo_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      mthi_q   <= mthi_d;
      mtlo_q   <= mtlo_d;
    end
  end

  // Stall drops in DONE so the instruction leaves EX on the edge its result lands.
  assign stall_req_o = (accept && rst_i) ||
                       ((state_q == MUL || state_q == DIV) && !flush_i);
  assign busy_o      = (state_q != IDLE);
  assign hi_we_o     = ((state_q == DONE) && !flush_i) || mthi_q;
  assign lo_we_o     = ((state_q == DONE) && !flush_i) || mtlo_q;
  assign hi_wdata_o  = acc_q[63:32];
  assign lo_wdata_o  = acc_q[31:0];
endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Scoreboard bench for muldiv_hilo_ctrl: stimulus pushes expected HI/LO writes,
// a negedge monitor pops and compares whenever a write strobe appears.
module tb_muldiv_hilo_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] opa = '0, opb = '0, mt_data = '0;
  logic        flush = 1'b0, mthi_we = 1'b0, mtlo_we = 1'b0;
  logic        stall_req, busy, hi_we, lo_we;
  logic [31:0] hi_wdata, lo_wdata;

  int n_chk = 0;
  int n_fail = 0;
  logic [65:0] sb[$];   // {hi_we, lo_we, hi, lo}

  muldiv_hilo_ctrl #(.ITER(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .opa_i(opa), .opb_i(opb),
    .flush_i(flush), .mthi_we_i(mthi_we), .mtlo_we_i(mtlo_we), .mt_data_i(mt_data),
    .stall_req_o(stall_req), .busy_o(busy), .hi_we_o(hi_we), .lo_we_o(lo_we),
    .hi_wdata_o(hi_wdata), .lo_wdata_o(lo_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && (hi_we || lo_we)) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: hi_we=%0b lo_we=%0b hi=%h lo=%h",
                 hi_we, lo_we, hi_wdata, lo_wdata);
      end else begin
        logic [65:0] e;
        e = sb.pop_front();
        if (hi_we !== e[65] || lo_we !== e[64] ||
            (e[65] && hi_wdata !== e[63:32]) || (e[64] && lo_wdata !== e[31:0])) begin
          n_fail++;
          $display("FAIL write_data: got we=%0b%0b hi=%h lo=%h expected we=%0b%0b hi=%h lo=%h",
                   hi_we, lo_we, hi_wdata, lo_wdata, e[65], e[64], e[63:32], e[31:0]);
        end
      end
    end
  end

  // noise: MTHI alongside start, and a second start plus MT request while busy.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a, b,
                        input logic [31:0] eh, el, input int lat, input bit noise);
    sb.push_back({2'b11, eh, el});
    @(posedge clk); #1;
    start = 1'b1; op = o; opa = a; opb = b;
    mthi_we = noise; mt_data = 32'hDEAD_BEEF;
    @(negedge clk);
    check({nm, "_stall_c0"}, 32'(stall_req), 32'd1);
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        start = 1'b0; mthi_we = 1'b0; opa = $urandom; opb = $urandom; op = 2'($urandom);
      end
      if (noise && c == 5) begin
        start = 1'b1; op = 2'b11; opb = 32'd0; mthi_we = 1'b1; mtlo_we = 1'b1;
      end
      if (noise && c == 6) begin
        start = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
      end
      @(negedge clk);
      if (c < lat) begin
        if (!stall_req || hi_we) check({nm, "_stall_busy"}, {30'd0, stall_req, hi_we}, 32'd2);
      end else begin
        check({nm, "_stall_done"}, 32'(stall_req), 32'd0);
        check({nm, "_strobe_lat"}, {30'd0, hi_we, lo_we}, 32'd3);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    check({nm, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  task automatic mt_write(input string nm, input logic h, l, input logic [31:0] d);
    sb.push_back({h, l, d, d});
    @(posedge clk); #1;
    mthi_we = h; mtlo_we = l; mt_data = d;
    @(posedge clk); #1;
    mthi_we = 1'b0; mtlo_we = 1'b0; mt_data = 32'h0;
    @(negedge clk);
    check({nm, "_we"}, {30'd0, hi_we, lo_we}, {30'd0, h, l});
    @(negedge clk);
    check({nm, "_we_once"}, {30'd0, hi_we, lo_we}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation time limit reached, expected $finish earlier");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #12;
    check("rst_outputs", {28'd0, stall_req, busy, hi_we, lo_we}, 32'd0);
    check("rst_hi_wdata", hi_wdata, 32'd0);
    check("rst_lo_wdata", lo_wdata, 32'd0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);

    run_op("multu_ff_x2",  2'b01, 32'hFFFF_FFFF, 32'h2,        32'h1,        32'hFFFF_FFFE, 33, 1'b0);
    run_op("mult_m3x7",    2'b00, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 1'b0);
    run_op("div_m7d2",     2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0);
    run_op("divu_100d0",   2'b11, 32'd100,       32'd0,        32'd100,      32'hFFFF_FFFF, 1,  1'b0);
    run_op("divu_100d7",   2'b11, 32'd100,       32'd7,        32'd2,        32'd14,        33, 1'b0);
    run_op("mult_min_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,       33, 1'b0);
    run_op("div_min_m1",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,       32'h8000_0000, 33, 1'b0);
    run_op("div_7dm2",     2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 33, 1'b0);
    run_op("multu_noise",  2'b01, 32'd6,         32'd7,        32'd0,        32'd42,        33, 1'b1);

    mt_write("mthi", 1'b1, 1'b0, 32'hA5A5_A5A5);
    mt_write("mtlo", 1'b0, 1'b1, 32'h0F0F_1234);
    mt_write("mthilo", 1'b1, 1'b1, 32'h1234_5678);

    // Flush at cycle 10 of a MULT
    @(posedge clk); #1; start = 1'b1; op = 2'b00; opa = 32'd9; opb = 32'd9;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #1; flush = 1'b1;
    @(negedge clk);
    check("flush_mul_stall", {30'd0, stall_req, hi_we}, 32'd0);
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    check("flush_mul_busy", 32'(busy), 32'd0);
    repeat (40) @(posedge clk);

    // Flush in the DONE cycle of a divide-by-zero
    @(posedge clk); #1; start = 1'b1; op = 2'b11; opa = 32'd5; opb = 32'd0;
    @(posedge clk); #1; start = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("flush_done_we", {29'd0, busy, hi_we, lo_we}, 32'd4);
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    check("flush_done_busy", 32'(busy), 32'd0);

    // Reset mid-DIV
    @(posedge clk); #1; start = 1'b1; op = 2'b11; opa = 32'hFFFF_0000; opb = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (6) @(posedge clk);
    #1; rst = 1'b0; start = 1'b1;
    #1;
    check("rst_mid_ctrl", {28'd0, stall_req, busy, hi_we, lo_we}, 32'd0);
    check("rst_mid_hi", hi_wdata, 32'd0);
    check("rst_mid_lo", lo_wdata, 32'd0);
    repeat (2) @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    repeat (40) @(negedge clk);

    check("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
